gf_serial_sequencer: RTL and testbench

- Upstream/downstream companion to the serialised GF operation top level.
- Accepts one parallel operation request (operands, polynomial grade, reduction polynomial, reduction input, function selects) over a valid/ready handshake.
- Shifts all five operand streams into the top level's serial input registers, pulses `enable`, and deserialises the `out` and `out_mult` streams back into parallel result words.
- Returns the results over a second valid/ready handshake.

---
 rtl/gf_serial_sequencer_if.sv | 51 +++++
 rtl/gf_serial_sequencer.sv | 147 ++++++++++++++
 tb/tb_gf_serial_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gf_serial_sequencer_if.sv
// Request/result and serial-stream bundle between the GF serial sequencer and its neighbours.
// slave = sequencer side, master = producer/consumer and serial top-level side.
interface gf_serial_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned GW = $clog2(DATA_WIDTH) + 1;

  logic                      req_valid;
  logic                      req_ready;
  logic [3:0]                req_func;
  logic [DATA_WIDTH-1:0]     req_a;
  logic [DATA_WIDTH-1:0]     req_b;
  logic [GW-1:0]             req_grade;
  logic [DATA_WIDTH:0]       req_poly;
  logic [2*DATA_WIDTH-1:0]   req_red;

  logic                      sum_funct;
  logic                      exp_funct;
  logic                      red_funct;
  logic                      carry_option;

  logic                      ser_a;
  logic                      ser_b;
  logic                      ser_grade;
  logic                      ser_poly;
  logic                      ser_red;
  logic                      enable;
  logic                      ser_out;
  logic                      ser_out_mult;

  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_WIDTH-1:0]     res_out;
  logic [2*DATA_WIDTH-1:0]   res_mult;

  modport slave (
    input  req_valid, req_func, req_a, req_b, req_grade, req_poly, req_red,
    input  ser_out, ser_out_mult, res_ready,
    output req_ready, sum_funct, exp_funct, red_funct, carry_option,
    output ser_a, ser_b, ser_grade, ser_poly, ser_red, enable,
    output res_valid, res_out, res_mult
  );

  modport master (
    output req_valid, req_func, req_a, req_b, req_grade, req_poly, req_red,
    output ser_out, ser_out_mult, res_ready,
    input  req_ready, sum_funct, exp_funct, red_funct, carry_option,
    input  ser_a, ser_b, ser_grade, ser_poly, ser_red, enable,
    input  res_valid, res_out, res_mult
  );
endinterface

// File: rtl/gf_serial_sequencer.sv
// Serialises one GF request into the serial top level, runs it, and deserialises the results.
// Define GF_SEQ_PERF_EN to add the op_count / busy_cycles performance counters.
module gf_serial_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned OUT_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  gf_serial_sequencer_if.slave   bus
`ifdef GF_SEQ_PERF_EN
  ,
  output logic [15:0]            op_count,
  output logic [31:0]            busy_cycles
`endif
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(W2) + 1;

  typedef enum logic [2:0] {StIdle, StShift, StExec, StWait, StCapture, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            req_ready_q;
  logic [3:0]      func_q;
  logic            enable_q;
  logic            res_valid_q;
  logic [W-1:0]    res_out_q;
  logic [W2-1:0]   res_mult_q;
  // Each stream is right-aligned in a 2W window and shifted out MSB first; the
  // window drains to zero by the end of SHIFT, so the lines idle low afterwards.
  logic [W2-1:0]   sh_a_q, sh_b_q, sh_grade_q, sh_poly_q, sh_red_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      func_q      <= '0;
      enable_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
      res_mult_q  <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      sh_grade_q  <= '0;
      sh_poly_q   <= '0;
      sh_red_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid && req_ready_q) begin
            func_q      <= bus.req_func;
            sh_a_q      <= W2'(bus.req_a);
            sh_b_q      <= W2'(bus.req_b);
            sh_grade_q  <= W2'(bus.req_grade);
            sh_poly_q   <= W2'(bus.req_poly);
            sh_red_q    <= bus.req_red;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= StShift;
          end
        end
        StShift: begin
          sh_a_q     <= {sh_a_q[W2-2:0], 1'b0};
          sh_b_q     <= {sh_b_q[W2-2:0], 1'b0};
          sh_grade_q <= {sh_grade_q[W2-2:0], 1'b0};
          sh_poly_q  <= {sh_poly_q[W2-2:0], 1'b0};
          sh_red_q   <= {sh_red_q[W2-2:0], 1'b0};
          if (cnt_q == CW'(W2 - 1)) begin
            cnt_q    <= '0;
            enable_q <= 1'b1;
            state_q  <= StExec;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StExec: begin
          if (cnt_q == CW'(EXEC_CYCLES - 1)) begin
            cnt_q    <= '0;
            enable_q <= 1'b0;
            state_q  <= (OUT_LAT == 0) ? StCapture : StWait;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StWait: begin
          if (cnt_q == CW'(OUT_LAT - 1)) begin
            cnt_q   <= '0;
            state_q <= StCapture;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StCapture: begin
          res_mult_q <= {res_mult_q[W2-2:0], bus.ser_out_mult};
          // Only the first W result bits are meaningful for the W-wide output.
          if (cnt_q < CW'(W)) res_out_q <= {res_out_q[W-2:0], bus.ser_out};
          if (cnt_q == CW'(W2 - 1)) begin
            cnt_q       <= '0;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          if (bus.res_ready) begin
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.sum_funct    = func_q[3];
  assign bus.exp_funct    = func_q[2];
  assign bus.red_funct    = func_q[1];
  assign bus.carry_option = func_q[0];
  assign bus.ser_a        = sh_a_q[W2-1];
  assign bus.ser_b        = sh_b_q[W2-1];
  assign bus.ser_grade    = sh_grade_q[W2-1];
  assign bus.ser_poly     = sh_poly_q[W2-1];
  assign bus.ser_red      = sh_red_q[W2-1];
  assign bus.enable       = enable_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_out      = res_out_q;
  assign bus.res_mult     = res_mult_q;

`ifdef GF_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count    <= '0;
      busy_cycles <= '0;
    end else begin
      if (state_q == StDone && bus.res_ready) op_count <= op_count + 16'd1;
      if (state_q != StIdle && busy_cycles != '1) busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_gf_serial_sequencer.sv
// Scoreboard bench for gf_serial_sequencer: serial stream alignment, enable timing, capture,
// back-pressure and mid-operation reset.
module tb_gf_serial_sequencer;
  localparam int unsigned W   = 8;
  localparam int unsigned W2  = 2 * W;
  localparam int unsigned GW  = $clog2(W) + 1;
  localparam int unsigned E   = 2;
  localparam int unsigned L   = 1;

  typedef struct packed {
    logic [W2-1:0] mult;
    logic [W-1:0]  out;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  res_t sb[$];

  gf_serial_sequencer_if #(.DATA_WIDTH(W)) bus ();

`ifdef GF_SEQ_PERF_EN
  logic [15:0] op_count;
  logic [31:0] busy_cycles;
`endif

  gf_serial_sequencer #(
    .DATA_WIDTH (W),
    .EXEC_CYCLES(E),
    .OUT_LAT    (L)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef GF_SEQ_PERF_EN
    ,
    .op_count   (op_count),
    .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
    check({tag, "_enable"}, 64'(bus.enable), 64'(0));
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'(0));
    check({tag, "_ser"}, 64'({bus.ser_a, bus.ser_b, bus.ser_grade, bus.ser_poly, bus.ser_red}),
          64'(0));
    check({tag, "_res_out"}, 64'(bus.res_out), 64'(0));
    check({tag, "_res_mult"}, 64'(bus.res_mult), 64'(0));
    check({tag, "_func"},
          64'({bus.sum_funct, bus.exp_funct, bus.red_funct, bus.carry_option}), 64'(0));
  endtask

  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [GW-1:0] g, input logic [W:0] p,
                          input logic [W2-1:0] r, input logic [3:0] f, output bit ok);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_grade = g;
    bus.req_poly  = p;
    bus.req_red   = r;
    bus.req_func  = f;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 64'(0), 64'(1));
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
    end
  endtask

  // hold: DONE cycles with res_ready low; hold==0 keeps res_ready high from the start.
  // pend: present a new request while back-pressured in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [GW-1:0] g, input logic [W:0] p,
                        input logic [W2-1:0] r, input logic [3:0] f,
                        input logic [W2-1:0] mult, input logic [W-1:0] out,
                        input int hold, input bit pend);
    res_t          e;
    res_t          exp_r;
    bit            ok;
    logic [W2-1:0] sa, sbb, sg, sp, sr;
    logic [63:0]   en_vec, exp_en;
    logic [4:0]    ser_or;
    bit            stable;
    logic          rr_or;
    e.mult = mult;
    e.out  = out;
    sb.push_back(e);
    bus.res_ready = (hold == 0);
    send_req(a, b, g, p, r, f, ok);
    if (!ok) begin
      void'(sb.pop_back());
      return;
    end
    en_vec = '0;
    sa = '0; sbb = '0; sg = '0; sp = '0; sr = '0;
    for (int i = 0; i < int'(W2); i++) begin
      @(negedge clk);
      sa  = {sa[W2-2:0], bus.ser_a};
      sbb = {sbb[W2-2:0], bus.ser_b};
      sg  = {sg[W2-2:0], bus.ser_grade};
      sp  = {sp[W2-2:0], bus.ser_poly};
      sr  = {sr[W2-2:0], bus.ser_red};
      en_vec[i] = bus.enable;
      if (i == 0)
        check("func_shift",
              64'({bus.sum_funct, bus.exp_funct, bus.red_funct, bus.carry_option}), 64'(f));
    end
    check("ser_a", 64'(sa), 64'(a));
    check("ser_b", 64'(sbb), 64'(b));
    check("ser_grade", 64'(sg), 64'(g));
    check("ser_poly", 64'(sp), 64'(p));
    check("ser_red", 64'(sr), 64'(r));
    ser_or = '0;
    for (int k = 0; k < int'(E + L); k++) begin
      @(negedge clk);
      en_vec[W2 + k] = bus.enable;
      ser_or |= {bus.ser_a, bus.ser_b, bus.ser_grade, bus.ser_poly, bus.ser_red};
    end
    check("ser_idle_exec", 64'(ser_or), 64'(0));
    for (int j = 0; j < int'(W2); j++) begin
      @(negedge clk);
      en_vec[W2 + E + L + j] = bus.enable;
      bus.ser_out_mult = mult[W2-1-j];
      bus.ser_out      = (j < int'(W)) ? out[W-1-j] : 1'($urandom_range(0, 1));
      if (j == int'(W2) - 1) check("res_valid_early", 64'(bus.res_valid), 64'(0));
    end
    exp_en = ((64'(1) << E) - 64'(1)) << W2;
    check("enable_window", en_vec, exp_en);
    @(negedge clk);
    bus.ser_out      = 1'b0;
    bus.ser_out_mult = 1'b0;
    check("res_valid_rise", 64'(bus.res_valid), 64'(1));
    if (sb.size() == 0) begin
      check("sb_empty", 64'(0), 64'(1));
      return;
    end
    exp_r = sb.pop_front();
    check("res_out", 64'(bus.res_out), 64'(exp_r.out));
    check("res_mult", 64'(bus.res_mult), 64'(exp_r.mult));
    check("func_done",
          64'({bus.sum_funct, bus.exp_funct, bus.red_funct, bus.carry_option}), 64'(f));
    stable = 1'b1;
    rr_or  = 1'b0;
    for (int k = 0; k < hold; k++) begin
      if (pend) bus.req_valid = 1'b1;
      @(negedge clk);
      stable &= bus.res_valid && (bus.res_out == exp_r.out) && (bus.res_mult == exp_r.mult);
      rr_or  |= bus.req_ready;
    end
    if (hold > 0) check("hold_stable", 64'(stable), 64'(1));
    if (pend) check("no_accept_in_done", 64'(rr_or), 64'(0));
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_done", 64'(bus.req_ready), 64'(1));
    check("valid_drop", 64'(bus.res_valid), 64'(0));
    bus.res_ready = 1'b0;
  endtask

  task automatic run_rand_op(input int hold, input bit pend);
    logic [W-1:0]  a, b, out;
    logic [GW-1:0] g;
    logic [W:0]    p;
    logic [W2-1:0] r, mult;
    logic [3:0]    f;
    a = W'($urandom); b = W'($urandom); out = W'($urandom);
    g = GW'($urandom); p = (W+1)'($urandom); r = W2'($urandom);
    mult = W2'($urandom); f = 4'($urandom);
    run_op(a, b, g, p, r, f, mult, out, hold, pend);
  endtask

  initial begin
    bit ok;
    bus.req_valid = 1'b0; bus.req_func = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_grade = '0; bus.req_poly = '0; bus.req_red = '0;
    bus.ser_out = 1'b0; bus.ser_out_mult = 1'b0; bus.res_ready = 1'b0;

    // Asynchronous reset asserted mid-cycle must take effect without a clock edge.
    #12 reset = 1'b1;
    #1 check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'hA5, 8'h3C, 4'h8, 9'h11B, 16'hBEEF, 4'b1010, 16'h3C5A, 8'hC3, 0, 1'b0);
    run_rand_op(0, 1'b0);
    run_rand_op(10, 1'b1);
    run_rand_op(0, 1'b0);

    // Abort in the 5th SHIFT cycle; no result may surface for it.
    send_req(8'h5A, 8'hF0, 4'h3, 9'h1FF, 16'h1234, 4'b0101, ok);
    if (ok) begin
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_state("abort");
      @(negedge clk);
      reset = 1'b0;
    end
`ifdef GF_SEQ_PERF_EN
    check("perf_ops_cleared", 64'(op_count), 64'(0));
`endif
    run_op(8'h81, 8'h7E, 4'h5, 9'h163, 16'h0F0F, 4'b1100, 16'hA55A, 8'h69, 0, 1'b0);
    run_rand_op(0, 1'b0);
    run_rand_op(0, 1'b0);
`ifdef GF_SEQ_PERF_EN
    check("perf_op_count", 64'(op_count), 64'(3));
    check("perf_busy", 64'(busy_cycles), 64'(3 * (W2 + E + L + W2 + 1)));
`endif
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
